// File: rtl/sdp_ram_ctrl.sv
// sdp_ram_ctrl: controller and arbiter for one byte-write, write-first simple-dual-port BRAM.
//   After reset, and on clear_req, it sweeps the whole array to INIT_VALUE.
//   In RUN it shares write port B between two valid/ready write requesters.
//   Requester 0 has fixed priority, limited by an anti-starvation streak guard.
//   It also serves one read requester on port A with a fixed 1-cycle latency.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   clear_req            restart the clear sweep (honoured only in RUN)
//   init_done            array usable (RUN state)
//   w0_* / w1_*          write requesters (valid/ready, addr, column strobes, data)
//   rd_req/rd_addr       read request; rd_ready accepts, rd_rvalid/rd_data one cycle later
//   ram_*                RAM macro interface (shared enable, port A read, port B byte write)
module sdp_ram_ctrl #(
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [NUM_COL*COL_WIDTH-1:0] INIT_VALUE = '0,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear_req,
    output logic                            init_done,
    input  logic                            w0_valid,
    output logic                            w0_ready,
    input  logic [ADDR_WIDTH-1:0]           w0_addr,
    input  logic [NUM_COL-1:0]              w0_strb,
    input  logic [NUM_COL*COL_WIDTH-1:0]    w0_data,
    input  logic                            w1_valid,
    output logic                            w1_ready,
    input  logic [ADDR_WIDTH-1:0]           w1_addr,
    input  logic [NUM_COL-1:0]              w1_strb,
    input  logic [NUM_COL*COL_WIDTH-1:0]    w1_data,
    input  logic                            rd_req,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    output logic                            rd_ready,
    output logic                            rd_rvalid,
    output logic [NUM_COL*COL_WIDTH-1:0]    rd_data,
    output logic                            ram_en,
    output logic [ADDR_WIDTH-1:0]           ram_addrA,
    input  logic [NUM_COL*COL_WIDTH-1:0]    ram_doutA,
    output logic [NUM_COL-1:0]              ram_wen,
    output logic [ADDR_WIDTH-1:0]           ram_addrB,
    output logic [NUM_COL*COL_WIDTH-1:0]    ram_dinB
);

    localparam int unsigned DATA_W   = NUM_COL * COL_WIDTH;
    localparam int unsigned STREAK_W = 4;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_STREAK);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [STREAK_W-1:0]   r_streak;
    logic                  r_rvalid;

    logic w_run;
    logic w_grant0;
    logic w_grant1;
    logic w_rd_acc;

    // Arbitration: port 0 wins unless port 1 is waiting and the streak is exhausted
    assign w_run    = (r_state == ST_RUN);
    assign w_grant0 = w_run & w0_valid & (~w1_valid | (r_streak < STREAK_MAX));
    assign w_grant1 = w_run & w1_valid & ~w_grant0;
    assign w_rd_acc = w_run & rd_req;

    assign init_done = w_run;
    assign rd_ready  = w_run;
    assign w0_ready  = w_grant0;
    assign w1_ready  = w_grant1;
    assign rd_rvalid = r_rvalid;
    assign rd_data   = ram_doutA;
    assign ram_addrA = rd_addr;
    assign ram_en    = ~w_run | w_rd_acc | w_grant0 | w_grant1;

    // Port B mux: sweep writes in INIT, arbitration winner in RUN
    always_comb begin
        ram_wen   = '0;
        ram_addrB = '0;
        ram_dinB  = '0;
        if (!w_run) begin
            ram_wen   = '1;
            ram_addrB = r_cnt;
            ram_dinB  = DATA_W'(INIT_VALUE);
        end else if (w_grant0) begin
            ram_wen   = w0_strb;
            ram_addrB = w0_addr;
            ram_dinB  = w0_data;
        end else if (w_grant1) begin
            ram_wen   = w1_strb;
            ram_addrB = w1_addr;
            ram_dinB  = w1_data;
        end
    end

    // State machine, sweep counter, streak counter and read-valid pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_INIT;
            r_cnt    <= '0;
            r_streak <= '0;
            r_rvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rvalid <= 1'b0;
                    if (r_cnt == LAST_ADDR) begin
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    // A read accepted in the clear_req cycle still returns its data
                    r_rvalid <= w_rd_acc;
                    if (clear_req) begin
                        r_state  <= ST_INIT;
                        r_cnt    <= '0;
                        r_streak <= '0;
                    end else if (w_grant1 || !w1_valid) begin
                        r_streak <= '0;
                    end else if (w_grant0 && (r_streak < STREAK_MAX)) begin
                        r_streak <= r_streak + STREAK_W'(1);
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sdp_ram_ctrl.sv
// Directed bench for sdp_ram_ctrl with a write-first byte-write RAM model.
module tb_sdp_ram_ctrl;

    localparam int unsigned NC = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = NC * CW;
    localparam logic [DW-1:0] INITV = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req;
    logic          init_done;
    logic          w0_valid, w0_ready;
    logic [AW-1:0] w0_addr;
    logic [NC-1:0] w0_strb;
    logic [DW-1:0] w0_data;
    logic          w1_valid, w1_ready;
    logic [AW-1:0] w1_addr;
    logic [NC-1:0] w1_strb;
    logic [DW-1:0] w1_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready, rd_rvalid;
    logic [DW-1:0] rd_data;
    logic          ram_en;
    logic [AW-1:0] ram_addrA, ram_addrB;
    logic [DW-1:0] ram_doutA, ram_dinB;
    logic [NC-1:0] ram_wen;

    int n_cmp = 0;
    int n_err = 0;

    sdp_ram_ctrl #(
        .NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW),
        .INIT_VALUE(INITV), .MAX_STREAK(4)
    ) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .init_done(init_done),
        .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr),
        .w0_strb(w0_strb), .w0_data(w0_data),
        .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr),
        .w1_strb(w1_strb), .w1_data(w1_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_rvalid(rd_rvalid), .rd_data(rd_data),
        .ram_en(ram_en), .ram_addrA(ram_addrA), .ram_doutA(ram_doutA),
        .ram_wen(ram_wen), .ram_addrB(ram_addrB), .ram_dinB(ram_dinB)
    );

    always #5 clk = ~clk;

    // Write-first byte-write SDP RAM model; holds doutA when ram_en is low
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] merged;
    initial ram_doutA = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            merged = mem[ram_addrB];
            for (int c = 0; c < int'(NC); c++)
                if (ram_wen[c]) merged[c*CW +: CW] = ram_dinB[c*CW +: CW];
            if (ram_wen != '0) mem[ram_addrB] <= merged;
            ram_doutA <= (ram_addrA == ram_addrB && ram_wen != '0) ? merged : mem[ram_addrA];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear_req = 0; w0_valid = 0; w1_valid = 0; rd_req = 0;
        w0_addr = '0; w0_strb = '0; w0_data = '0;
        w1_addr = '0; w1_strb = '0; w1_data = '0;
        rd_addr = '0;
    endtask

    // Counts edges until init_done rises, bounded
    task automatic wait_init(input string tag, input int exp_cycles);
        int n = 0;
        while (!init_done && n < 64) begin
            tick();
            n++;
        end
        check(tag, DW'(n), DW'(exp_cycles));
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_req = 1; rd_addr = a;
        @(negedge clk);
        check({tag, "_ready"}, DW'(rd_ready), DW'(1));
        tick();
        rd_req = 0;
        check({tag, "_rvalid"}, DW'(rd_rvalid), DW'(1));
        check({tag, "_data"}, rd_data, exp);
    endtask

    logic exp_g1 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) tick();
        check("rst_init_done", DW'(init_done), DW'(0));
        check("rst_rvalid", DW'(rd_rvalid), DW'(0));
        check("rst_ram_en", DW'(ram_en), DW'(1));
        check("rst_ram_wen", DW'(ram_wen), DW'(4'hF));
        check("rst_addrB", DW'(ram_addrB), DW'(0));
        check("rst_dinB", ram_dinB, INITV);
        check("rst_rd_ready", DW'(rd_ready), DW'(0));

        // Abort mid-sweep at address 7, then a full sweep
        @(negedge clk); rst = 0;
        repeat (7) tick();
        check("sweep_addr7", DW'(ram_addrB), DW'(7));
        rst = 1;
        #1;
        check("abort_addrB", DW'(ram_addrB), DW'(0));
        check("abort_init_done", DW'(init_done), DW'(0));
        @(negedge clk); rst = 0;
        wait_init("sweep_len", 16);

        for (int i = 0; i < 16; i++) read_check($sformatf("rd%0d", i), AW'(i), INITV);
        tick();
        check("rvalid_drop", DW'(rd_rvalid), DW'(0));

        // Idle RUN
        @(negedge clk);
        check("idle_en", DW'(ram_en), DW'(0));
        check("idle_wen", DW'(ram_wen), DW'(0));
        check("idle_rvalid", DW'(rd_rvalid), DW'(0));

        // Both writers contend
        tick();
        w0_valid = 1; w0_addr = 4'd1; w0_strb = 4'hF; w0_data = 32'hAAAA0001;
        w1_valid = 1; w1_addr = 4'd2; w1_strb = 4'hF; w1_data = 32'hBBBB0002;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("arb%0d_g1", i), DW'(w1_ready), DW'(exp_g1[i]));
            check($sformatf("arb%0d_g0", i), DW'(w0_ready), DW'(!exp_g1[i]));
            check($sformatf("arb%0d_addrB", i), DW'(ram_addrB), exp_g1[i] ? DW'(2) : DW'(1));
            tick();
        end
        w0_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("w1only%0d", i), DW'(w1_ready), DW'(1));
            tick();
        end
        w1_valid = 0;
        read_check("rd_a1", 4'd1, 32'hAAAA0001);
        read_check("rd_a2", 4'd2, 32'hBBBB0002);

        // Byte write with same-cycle read of the same address
        w0_valid = 1; w0_addr = 4'd3; w0_strb = 4'b0101; w0_data = 32'h11223344;
        rd_req = 1; rd_addr = 4'd3;
        @(negedge clk);
        check("bw_ready", DW'(w0_ready), DW'(1));
        check("bw_wen", DW'(ram_wen), DW'(4'b0101));
        tick();
        w0_valid = 0; rd_req = 0;
        check("bw_rvalid", DW'(rd_rvalid), DW'(1));
        check("bw_data", rd_data, 32'hDE22BE44);

        // Zero-strobe write is still granted and changes nothing
        w0_valid = 1; w0_addr = 4'd3; w0_strb = 4'b0000; w0_data = 32'hFFFFFFFF;
        @(negedge clk);
        check("z_ready", DW'(w0_ready), DW'(1));
        check("z_wen", DW'(ram_wen), DW'(0));
        check("z_en", DW'(ram_en), DW'(1));
        tick();
        w0_valid = 0;
        read_check("z_rd", 4'd3, 32'hDE22BE44);

        // clear_req with a pending w1 write
        clear_req = 1;
        w1_valid = 1; w1_addr = 4'd5; w1_strb = 4'hF; w1_data = 32'h12345678;
        @(negedge clk);
        check("clr_w1_ready", DW'(w1_ready), DW'(1));
        tick();
        clear_req = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("clr%0d_rdy", i), DW'({w0_ready, w1_ready, rd_ready, init_done}), DW'(0));
            check($sformatf("clr%0d_addrB", i), DW'(ram_addrB), DW'(i));
            tick();
        end
        check("clr_done", DW'(init_done), DW'(1));
        w1_valid = 0;
        read_check("clr_rd3", 4'd3, INITV);
        read_check("clr_rd5", 4'd5, INITV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
